// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with multi-step advance,
// seed load, zero-lockup recovery and period tracking.
module lfsr_gen #(
  parameter int               NBITS = 16,
  parameter logic [NBITS-1:0] TAPS  = 16'hB400,
  parameter int               MODE  = 0,
  parameter logic [NBITS-1:0] SEED  = 16'hACE1,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [NBITS-1:0] load_data,
  output logic [NBITS-1:0] q,
  output logic             bit_out,
  output logic             lockup,
  output logic             wrap,
  output logic [NBITS-1:0] period
);

  if (NBITS < 3 || NBITS > 32) begin : g_bad_nbits
    $error("lfsr_gen: NBITS must be 3..32");
  end
  if (STEPS < 1 || STEPS > NBITS) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be 1..NBITS");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end

  logic [1:0]       rsync;
  logic             rst_n;
  logic [NBITS-1:0] state;
  logic [NBITS-1:0] ref_st;
  logic [NBITS-1:0] cnt;
  logic [NBITS-1:0] adv;
  logic             adv_out;

  // reset asserts at once, releases two edges later in the clk domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rsync <= '0;
    else      rsync <= {rsync[0], 1'b1};
  end

  assign rst_n = rsync[1];

  // STEPS single-step shifts unrolled into one combinational advance
  always_comb begin
    logic [NBITS-1:0] s;
    logic             o;
    s = state;
    o = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      o = s[NBITS-1];
      if (MODE == 0)
        s = {s[NBITS-2:0], ^(s & TAPS)};
      else
        s = {s[NBITS-2:0], 1'b0} ^ (o ? TAPS : '0);
    end
    adv     = s;
    adv_out = o;
  end

  // state, reference, period counter and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEED;
      ref_st  <= SEED;
      cnt     <= '0;
      period  <= '0;
      bit_out <= 1'b0;
      lockup  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      lockup <= 1'b0;
      wrap   <= 1'b0;
      if (load) begin
        cnt <= '0;
        if (load_data != '0) begin
          state  <= load_data;
          ref_st <= load_data;
        end else begin
          state  <= SEED;
          ref_st <= SEED;
          lockup <= 1'b1;
        end
      end else if (en) begin
        state   <= adv;
        bit_out <= adv_out;
        if (adv == ref_st) begin
          wrap   <= 1'b1;
          period <= cnt + 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign q = state;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen in default, 4-bit
// Fibonacci (1 and 3 steps) and 4-bit Galois configurations.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  logic        d_en = 0, d_load = 0;
  logic [15:0] d_data = '0, d_q, d_per;
  logic        d_bo, d_lk, d_wr;

  logic       a_en = 0, a_load = 0;
  logic [3:0] a_data = '0, a_q, a_per;
  logic       a_bo, a_lk, a_wr;

  logic       b_en = 0, b_load = 0;
  logic [3:0] b_data = '0, b_q, b_per;
  logic       b_bo, b_lk, b_wr;

  logic       g_en = 0, g_load = 0;
  logic [3:0] g_data = '0, g_q, g_per;
  logic       g_bo, g_lk, g_wr;

  lfsr_gen u_d (
    .clk(clk), .rst(rst), .en(d_en), .load(d_load),
    .load_data(d_data), .q(d_q), .bit_out(d_bo),
    .lockup(d_lk), .wrap(d_wr), .period(d_per)
  );

  lfsr_gen #(
    .NBITS(4), .TAPS(4'b1100), .MODE(0), .SEED(4'h1), .STEPS(1)
  ) u_a (
    .clk(clk), .rst(rst), .en(a_en), .load(a_load),
    .load_data(a_data), .q(a_q), .bit_out(a_bo),
    .lockup(a_lk), .wrap(a_wr), .period(a_per)
  );

  lfsr_gen #(
    .NBITS(4), .TAPS(4'b1100), .MODE(0), .SEED(4'h1), .STEPS(3)
  ) u_b (
    .clk(clk), .rst(rst), .en(b_en), .load(b_load),
    .load_data(b_data), .q(b_q), .bit_out(b_bo),
    .lockup(b_lk), .wrap(b_wr), .period(b_per)
  );

  lfsr_gen #(
    .NBITS(4), .TAPS(4'b0011), .MODE(1), .SEED(4'h1), .STEPS(1)
  ) u_g (
    .clk(clk), .rst(rst), .en(g_en), .load(g_load),
    .load_data(g_data), .q(g_q), .bit_out(g_bo),
    .lockup(g_lk), .wrap(g_wr), .period(g_per)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nw;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_q", 32'(d_q), 32'hACE1);
    check("rst_bo", 32'(d_bo), 32'h0);
    check("rst_per", 32'(d_per), 32'h0);

    d_en = 1'b1;
    tick();
    check("fib1_q", 32'(d_q), 32'h59C3);
    check("fib1_bo", 32'(d_bo), 32'h1);
    tick();
    check("fib2_q", 32'(d_q), 32'hB387);
    check("fib2_bo", 32'(d_bo), 32'h0);
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_q", 32'(d_q), 32'hACE1);
    check("arst_bo", 32'(d_bo), 32'h0);
    d_en = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("hold_q", 32'(d_q), 32'hACE1);
    check("hold_wr", 32'(d_wr), 32'h0);
    check("hold_lk", 32'(d_lk), 32'h0);
    check("hold_per", 32'(d_per), 32'h0);

    d_en = 1'b1;
    tick();
    check("pre_lk_q", 32'(d_q), 32'h59C3);
    d_load = 1'b1;
    d_data = 16'h0000;
    tick();
    check("lk_q", 32'(d_q), 32'hACE1);
    check("lk_pulse", 32'(d_lk), 32'h1);
    d_load = 1'b0;
    d_en = 1'b0;
    tick();
    check("lk_clr", 32'(d_lk), 32'h0);
    check("lk_hold_q", 32'(d_q), 32'hACE1);
    d_load = 1'b1;
    d_en = 1'b1;
    d_data = 16'h1234;
    tick();
    check("ld_q", 32'(d_q), 32'h1234);
    check("ld_lk", 32'(d_lk), 32'h0);
    check("ld_wr", 32'(d_wr), 32'h0);
    d_load = 1'b0;
    d_en = 1'b0;

    g_load = 1'b1;
    g_data = 4'h8;
    tick();
    check("gal_ld", 32'(g_q), 32'h8);
    g_load = 1'b0;
    g_en = 1'b1;
    tick();
    check("gal1_q", 32'(g_q), 32'h3);
    check("gal1_bo", 32'(g_bo), 32'h1);
    tick();
    check("gal2_q", 32'(g_q), 32'h6);
    check("gal2_bo", 32'(g_bo), 32'h0);
    g_en = 1'b0;

    a_en = 1'b1;
    b_en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      check("a_wrap", 32'(a_wr), 32'((i % 15) == 0));
      check("b_wrap", 32'(b_wr), 32'((i % 5) == 0));
      if (a_wr) begin
        check("a_wq", 32'(a_q), 32'h1);
        check("a_per", 32'(a_per), 32'd15);
      end
      if (b_wr) begin
        check("b_wq", 32'(b_q), 32'h1);
        check("b_per", 32'(b_per), 32'd5);
      end
    end
    a_en = 1'b0;
    b_en = 1'b0;

    d_en = 1'b1;
    repeat (7) tick();
    d_load = 1'b1;
    d_data = 16'h0001;
    tick();
    check("mid_ld_q", 32'(d_q), 32'h0001);
    check("mid_ld_wr", 32'(d_wr), 32'h0);
    d_load = 1'b0;
    nw = 0;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (i < 65535 && d_wr) nw++;
    end
    check("long_early", 32'(nw), 32'h0);
    check("long_wr", 32'(d_wr), 32'h1);
    check("long_q", 32'(d_q), 32'h0001);
    check("long_per", 32'(d_per), 32'hFFFF);
    d_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised pseudo-random sequence generator; next generation of the fixed 16-bit shift-register PRNG.
- Supports Fibonacci or Galois form, any width 3..32 and an arbitrary tap mask.
- Can advance several steps per clock, with seed load and zero-lockup protection.
- Tracks the sequence period (wrap back to the last loaded state) for test-pattern and replay-scrambler use.

Parameters:
- NBITS, 16: register width, legal 3..32.
- TAPS, 16'hB400: feedback mask; bit i set means x^(i+1) is in the polynomial. Default is x16+x14+x13+x11+1.
- MODE, 0: 0 = Fibonacci (external XOR), 1 = Galois (internal XOR).
- SEED, 16'hACE1: reset and lockup-recovery state; must be nonzero.
- STEPS, 1: single-step shifts applied per enabled cycle, legal 1..NBITS.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- en, in, 1: advance STEPS shifts this cycle.
- load, in, 1: load load_data this cycle.
- load_data, in, NBITS: new state or seed.
- q, out, NBITS: current register state.
- bit_out, out, 1: MSB shifted out by the last single step of the previous enabled cycle.
- lockup, out, 1: one-cycle pulse; a zero load was replaced by SEED.
- wrap, out, 1: one-cycle pulse; the state returned to the reference state.
- period, out, NBITS: step-call count of the last completed period.

Behaviour:
- Reset (rst low, async; released synchronously by the design):
  - state = SEED, ref = SEED, q = SEED.
  - bit_out = 0, lockup = 0, wrap = 0, period = 0, cnt = 0.
- Precedence each cycle: load over en over hold.
- Load:
  - If load_data != 0: state = load_data, ref = load_data, cnt = 0.
  - If load_data == 0: state = SEED, ref = SEED, cnt = 0, lockup = 1 next cycle.
  - Load never asserts wrap. bit_out and period hold.
- Single step, Fibonacci:
  - fb = XOR of state bits selected by TAPS.
  - next = {state[NBITS-2:0], fb}.
  - out = state[NBITS-1].
- Single step, Galois:
  - out = state[NBITS-1].
  - next = {state[NBITS-2:0], 1'b0} XOR (out ? TAPS : 0).
- Enabled cycle: apply the single step STEPS times combinationally. Registered results:
  - new state.
  - bit_out = out of the final step.
  - cnt = cnt + 1 (wraps modulo 2^NBITS).
- Wrap:
  - If the post-advance state equals ref: wrap = 1 next cycle, period = cnt + 1, cnt = 0.
  - Only the end state of a multi-step advance is compared.
- Hold (en = 0, load = 0): state, bit_out, cnt and period hold. lockup and wrap return to 0.
- Latency: q reflects load or advance one cycle after the qualifying edge; wrap and lockup align with that q.
- All-zero state is unreachable from any legal state. No combinational path from inputs to outputs.
- Reset mid-advance or mid-load: the async reset wins immediately and all outputs go to their reset values.
- Parameter checks: an illegal NBITS, STEPS or SEED = 0 triggers an elaboration-time error; the block has no runtime fallback.

Test Plan:
- Reset, defaults: assert rst low mid-run with en = 1 -> q = 16'hACE1 immediately. Release rst and hold en = 0 -> q stays 16'hACE1, wrap = 0, lockup = 0, period = 0.
- Fibonacci step, defaults: en = 1 for 2 cycles from reset -> q = 16'h59C3, then 16'hB387. bit_out = 1, then 0.
- Period, NBITS = 4, TAPS = 4'b1100, SEED = 4'h1: hold en = 1 -> wrap pulses exactly every 15 cycles, q = 4'h1 on the wrap cycle, period = 15. Repeat with STEPS = 3 -> wrap every 5 cycles, period = 5.
- Galois, NBITS = 4, MODE = 1, TAPS = 4'b0011: load 4'h8 then en = 1 -> q = 4'h3, bit_out = 1. Next step -> q = 4'h6, bit_out = 0.
- Lockup and precedence, defaults:
  - load = 1 with load_data = 0 and en = 1 -> q = 16'hACE1, lockup = 1 for one cycle, no advance.
  - load 16'h1234 with en = 1 -> q = 16'h1234, not advanced.
- Load mid-period: after 7 steps, load 16'h0001 -> cnt clears and ref becomes 16'h0001. Then step 2^16-1 times -> wrap fires with period = 16'hFFFF.
